frog_round_ctrl: RTL and testbench
==================================

FROG_ROUND_CTRL -- requirements
Module: frog_round_ctrl

Interface
REQ-001 SHALL expose parameter VIDAS_INI, default 3, lives loaded at game start (1..2^DATAWIDTH_VIDAS-1).
REQ-002 SHALL expose parameter DATAWIDTH_VIDAS, default 2, width of the lives counter.
REQ-003 SHALL expose parameter META_PUNTOS, default 5, goals needed for victory (1..2^DATAWIDTH_PUNTOS-1).
REQ-004 SHALL expose parameter DATAWIDTH_PUNTOS, default 3, width of the score counter.
REQ-005 SHALL expose parameter HOLD_CYCLES, default 50000000, length of the death/goal hold in clocks.
REQ-006 SHALL expose parameter DATAWIDTH_HOLD, default 26, width of the hold timer.
REQ-007 SHALL have port CIR_CLOCK_50  input  1  system clock, 50 MHz.
REQ-008 SHALL have port CIR_RESET  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port CIR_START_IN  input  1  start button, level, already synchronous.
REQ-010 SHALL have port CIR_PERDIO_IN  input  1  frog collision/drown flag.
REQ-011 SHALL have port CIR_GANO_IN  input  1  frog reached goal row.
REQ-012 SHALL have port CIR_ESTADO_OUT  output  3  game-state code.
REQ-013 SHALL have port CIR_VIDAS_OUT  output  DATAWIDTH_VIDAS  remaining lives.
REQ-014 SHALL have port CIR_PUNTOS_OUT  output  DATAWIDTH_PUNTOS  goals scored.
REQ-015 SHALL have port CIR_RANA_INI_OUT  output  1  one-clock frog-respawn pulse.
REQ-016 SHALL have port CIR_BLOQUEO_OUT  output  1  freeze frog/lane movement.

Function
REQ-017 SHALL implement a Moore FSM: IDLE=000, PLAY=111, DEAD=001, POINT=010, OVER=100, VICTORY=110; CIR_ESTADO_OUT equals the current state code.
REQ-018 SHALL detect a START rising edge as START_IN=1 with the previous-cycle register=0.
REQ-019 IDLE: a START edge SHALL load lives=VIDAS_INI and score=0 and move to PLAY.
REQ-020 PLAY: PERDIO_IN=1 SHALL move to DEAD and decrement lives on the same edge.
REQ-021 PLAY: PERDIO_IN=0 with GANO_IN=1 SHALL move to POINT and increment the score on the same edge.
REQ-022 PLAY: when PERDIO_IN and GANO_IN are both 1, PERDIO SHALL win (DEAD, no score change).
REQ-023 DEAD/POINT SHALL last exactly HOLD_CYCLES clocks; the timer clears on entry and expires at HOLD_CYCLES-1.
REQ-024 DEAD on expiry SHALL go to OVER if lives==0, else to PLAY.
REQ-025 POINT on expiry SHALL go to VICTORY if score==META_PUNTOS, else to PLAY.
REQ-026 In DEAD/POINT, PERDIO_IN/GANO_IN SHALL be ignored.
REQ-027 OVER/VICTORY SHALL hold until a START edge, then go to IDLE; lives and score stay frozen until then.
REQ-028 CIR_RANA_INI_OUT SHALL be 1 for exactly the first clock of every PLAY entry (from IDLE, DEAD or POINT), registered, 0 otherwise.
REQ-029 CIR_BLOQUEO_OUT SHALL be 1 in every state except PLAY.
REQ-030 Lives SHALL never underflow and score SHALL never exceed META_PUNTOS; no wrap-around is permitted.
REQ-031 A START level held high SHALL produce only one edge, so IDLE is not skipped into PLAY from OVER/VICTORY.

Reset
REQ-032 CIR_RESET=1 SHALL asynchronously force IDLE, lives=VIDAS_INI, score=0, timer=0, START history=0, RANA_INI_OUT=0, at any point including mid-hold.
REQ-033 During reset, outputs SHALL be: ESTADO=000, BLOQUEO=1, RANA_INI=0.

Structure
REQ-034 State codes and parameter defaults SHALL live in a shared package with the other CONTROL_RANAS controllers; PLAY=111 matches the "game running" code those controllers decode.
REQ-035 The hold timer SHALL be one sub-module, frog_hold_timer (inputs clear and enable, output expire), parameterised by HOLD_CYCLES/DATAWIDTH_HOLD.
REQ-036 All state, counters and RANA_INI SHALL be registered on CIR_CLOCK_50; next-state logic is combinational.

Verification (bench uses HOLD_CYCLES=4)
REQ-037 Reset, then a START pulse -> ESTADO 000->111, VIDAS=3, PUNTOS=0, RANA_INI high exactly 1 clock, BLOQUEO 0.
REQ-038 In PLAY, PERDIO one clock -> DEAD for 4 clocks, VIDAS=2, then PLAY with a 1-clock RANA_INI; repeat 3x -> ESTADO=100, VIDAS=0.
REQ-039 GANO five times with 4-clock holds -> PUNTOS 1..5, ESTADO=110 after the fifth hold, no RANA_INI after the fifth.
REQ-040 PERDIO and GANO together in PLAY -> DEAD, VIDAS decremented, PUNTOS unchanged.
REQ-041 Reset asserted at hold clock 2 of DEAD -> immediate ESTADO=000, VIDAS=3, PUNTOS=0; START held high across the deassert -> no PLAY entry until released and pressed again.
REQ-042 START held high in OVER -> one transition to IDLE only; a second edge is required to enter PLAY.

Source files
------------

// File: rtl/frog_round_ctrl_pkg.sv
// Shared game-state codes and defaults for the CONTROL_RANAS controllers.
// PLAY=111 is the "game running" code the lane/frog controllers decode.
package frog_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_DEAD    = 3'b001,
    ST_POINT   = 3'b010,
    ST_OVER    = 3'b100,
    ST_VICTORY = 3'b110,
    ST_PLAY    = 3'b111
  } state_t;

  localparam int VIDAS_INI_DEF        = 3;
  localparam int DATAWIDTH_VIDAS_DEF  = 2;
  localparam int META_PUNTOS_DEF      = 5;
  localparam int DATAWIDTH_PUNTOS_DEF = 3;
  localparam int HOLD_CYCLES_DEF      = 50000000;
  localparam int DATAWIDTH_HOLD_DEF   = 26;

  function automatic logic is_hold(state_t s);
    return (s == ST_DEAD) || (s == ST_POINT);
  endfunction

endpackage

// File: rtl/frog_round_ctrl_if.sv
// Game-round signal bundle between the input side and the round controller.
// master drives buttons/flags, slave is the controller.
interface frog_round_ctrl_if #(
  parameter int DW_V = 2,
  parameter int DW_P = 3
);
  logic            start;
  logic            perdio;
  logic            gano;
  logic [2:0]      estado;
  logic [DW_V-1:0] vidas;
  logic [DW_P-1:0] puntos;
  logic            rana_ini;
  logic            bloqueo;

  modport master (
    output start, perdio, gano,
    input  estado, vidas, puntos, rana_ini, bloqueo
  );

  modport slave (
    input  start, perdio, gano,
    output estado, vidas, puntos, rana_ini, bloqueo
  );
endinterface

// File: rtl/frog_round_ctrl_hold_timer.sv
// Death/goal hold timer: counts while enabled, expires on the last clock.
// Cleared whenever the controller is outside a hold state.
module frog_hold_timer #(
  parameter int HOLD_CYCLES    = 50000000,
  parameter int DATAWIDTH_HOLD = 26
) (
  input  logic CIR_CLOCK_50,
  input  logic CIR_RESET,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [DATAWIDTH_HOLD-1:0] LAST =
    DATAWIDTH_HOLD'(HOLD_CYCLES - 1);

  logic [DATAWIDTH_HOLD-1:0] cnt_q, cnt_d;

  assign expire = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expire)
      cnt_d = '0;
    else if (enable)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CIR_CLOCK_50 or posedge CIR_RESET) begin
    if (CIR_RESET)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frog_round_ctrl.sv
// Frogger round controller: start/lives/score FSM with death and goal holds.
// All outputs come straight from registers.
module frog_round_ctrl
  import frog_round_ctrl_pkg::*;
#(
  parameter int VIDAS_INI        = VIDAS_INI_DEF,
  parameter int DATAWIDTH_VIDAS  = DATAWIDTH_VIDAS_DEF,
  parameter int META_PUNTOS      = META_PUNTOS_DEF,
  parameter int DATAWIDTH_PUNTOS = DATAWIDTH_PUNTOS_DEF,
  parameter int HOLD_CYCLES      = HOLD_CYCLES_DEF,
  parameter int DATAWIDTH_HOLD   = DATAWIDTH_HOLD_DEF
) (
  input  logic                        CIR_CLOCK_50,
  input  logic                        CIR_RESET,
  input  logic                        CIR_START_IN,
  input  logic                        CIR_PERDIO_IN,
  input  logic                        CIR_GANO_IN,
  output logic [2:0]                  CIR_ESTADO_OUT,
  output logic [DATAWIDTH_VIDAS-1:0]  CIR_VIDAS_OUT,
  output logic [DATAWIDTH_PUNTOS-1:0] CIR_PUNTOS_OUT,
  output logic                        CIR_RANA_INI_OUT,
  output logic                        CIR_BLOQUEO_OUT
);

  localparam logic [DATAWIDTH_VIDAS-1:0] V_INI =
    DATAWIDTH_VIDAS'(VIDAS_INI);
  localparam logic [DATAWIDTH_PUNTOS-1:0] P_META =
    DATAWIDTH_PUNTOS'(META_PUNTOS);

  state_t                      state_q, state_d;
  logic [DATAWIDTH_VIDAS-1:0]  vidas_q, vidas_d;
  logic [DATAWIDTH_PUNTOS-1:0] puntos_q, puntos_d;
  logic                        rana_q, rana_d;
  logic                        bloqueo_q, bloqueo_d;
  logic                        start_prev_q, start_prev_d;
  logic                        armed_q, armed_d;
  logic                        start_edge;
  logic                        hold, expire;

  // START must be seen low once after reset before an edge counts,
  // so a button held through reset cannot launch a game.
  assign start_edge = CIR_START_IN & ~start_prev_q & armed_q;
  assign hold       = is_hold(state_q);

  frog_hold_timer #(
    .HOLD_CYCLES    (HOLD_CYCLES),
    .DATAWIDTH_HOLD (DATAWIDTH_HOLD)
  ) u_hold (
    .CIR_CLOCK_50 (CIR_CLOCK_50),
    .CIR_RESET    (CIR_RESET),
    .clear        (~hold),
    .enable       (hold),
    .expire       (expire)
  );

  always_comb begin
    state_d      = state_q;
    vidas_d      = vidas_q;
    puntos_d     = puntos_q;
    rana_d       = 1'b0;
    start_prev_d = CIR_START_IN;
    armed_d      = armed_q | ~CIR_START_IN;
    unique case (state_q)
      ST_IDLE: if (start_edge) begin
        state_d  = ST_PLAY;
        vidas_d  = V_INI;
        puntos_d = '0;
        rana_d   = 1'b1;
      end
      ST_PLAY: if (CIR_PERDIO_IN) begin
        state_d = ST_DEAD;
        if (vidas_q != '0)
          vidas_d = vidas_q - 1'b1;
      end else if (CIR_GANO_IN) begin
        state_d = ST_POINT;
        if (puntos_q < P_META)
          puntos_d = puntos_q + 1'b1;
      end
      ST_DEAD: if (expire) begin
        state_d = (vidas_q == '0) ? ST_OVER : ST_PLAY;
        rana_d  = (vidas_q != '0);
      end
      ST_POINT: if (expire) begin
        state_d = (puntos_q == P_META) ? ST_VICTORY : ST_PLAY;
        rana_d  = (puntos_q != P_META);
      end
      ST_OVER, ST_VICTORY: if (start_edge)
        state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    bloqueo_d = (state_d != ST_PLAY);
  end

  always_ff @(posedge CIR_CLOCK_50 or posedge CIR_RESET) begin
    if (CIR_RESET) begin
      state_q      <= ST_IDLE;
      vidas_q      <= V_INI;
      puntos_q     <= '0;
      rana_q       <= 1'b0;
      bloqueo_q    <= 1'b1;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vidas_q      <= vidas_d;
      puntos_q     <= puntos_d;
      rana_q       <= rana_d;
      bloqueo_q    <= bloqueo_d;
      start_prev_q <= start_prev_d;
      armed_q      <= armed_d;
    end
  end

  assign CIR_ESTADO_OUT   = state_q;
  assign CIR_VIDAS_OUT    = vidas_q;
  assign CIR_PUNTOS_OUT   = puntos_q;
  assign CIR_RANA_INI_OUT = rana_q;
  assign CIR_BLOQUEO_OUT  = bloqueo_q;

endmodule

// File: tb/tb_frog_round_ctrl.sv
// Bench for frog_round_ctrl: directed scenarios plus random play,
// checked against a phase/countdown model of the game rules.
module tb_frog_round_ctrl;

  localparam int HOLD = 4;
  localparam int VI   = 3;
  localparam int META = 5;

  logic clk;
  logic rst;

  frog_round_ctrl_if #(.DW_V(2), .DW_P(3)) gif();

  frog_round_ctrl #(
    .VIDAS_INI        (VI),
    .DATAWIDTH_VIDAS  (2),
    .META_PUNTOS      (META),
    .DATAWIDTH_PUNTOS (3),
    .HOLD_CYCLES      (HOLD),
    .DATAWIDTH_HOLD   (3)
  ) dut (
    .CIR_CLOCK_50     (clk),
    .CIR_RESET        (rst),
    .CIR_START_IN     (gif.start),
    .CIR_PERDIO_IN    (gif.perdio),
    .CIR_GANO_IN      (gif.gano),
    .CIR_ESTADO_OUT   (gif.estado),
    .CIR_VIDAS_OUT    (gif.vidas),
    .CIR_PUNTOS_OUT   (gif.puntos),
    .CIR_RANA_INI_OUT (gif.rana_ini),
    .CIR_BLOQUEO_OUT  (gif.bloqueo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // phases: 0 idle, 1 play, 2 dead, 3 point, 4 over, 5 victory
  int m_ph;
  int m_lives;
  int m_score;
  int m_left;
  bit m_rana;
  bit m_prev;
  bit m_seen_low;

  function automatic logic [2:0] code_of(int ph);
    case (ph)
      1: return 3'b111;
      2: return 3'b001;
      3: return 3'b010;
      4: return 3'b100;
      5: return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [9:0] exp_vec();
    logic b;
    b = (m_ph != 1);
    return {code_of(m_ph), 2'(m_lives), 3'(m_score), m_rana, b};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {gif.estado, gif.vidas, gif.puntos,
            gif.rana_ini, gif.bloqueo};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_lives = VI; m_score = 0; m_left = 0;
    m_rana = 0; m_prev = 0; m_seen_low = 0;
  endtask

  task automatic model_step(bit s, bit p, bit g);
    bit e;
    e = s && !m_prev && m_seen_low;
    if (!s) m_seen_low = 1;
    m_prev = s;
    m_rana = 0;
    case (m_ph)
      0: if (e) begin
        m_ph = 1; m_lives = VI; m_score = 0; m_rana = 1;
      end
      1: if (p) begin
        m_ph = 2; m_left = HOLD;
        if (m_lives > 0) m_lives--;
      end else if (g) begin
        m_ph = 3; m_left = HOLD;
        if (m_score < META) m_score++;
      end
      2, 3: begin
        m_left--;
        if (m_left == 0) begin
          if (m_ph == 2 && m_lives == 0) m_ph = 4;
          else if (m_ph == 3 && m_score == META) m_ph = 5;
          else begin m_ph = 1; m_rana = 1; end
        end
      end
      default: if (e) m_ph = 0;
    endcase
  endtask

  task automatic tick(bit s, bit p, bit g);
    gif.start = s; gif.perdio = p; gif.gano = g;
    @(posedge clk);
    model_step(s, p, g);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gif.start = 0; gif.perdio = 0; gif.gano = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs_vec() !== 10'b000_11_000_0_1) begin
      miscompares++;
      $display("FAIL reset: got %b want %b",
               obs_vec(), 10'b000_11_000_0_1);
    end
    rst = 1'b0;
    tick(0, 0, 0);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_idle: got %b want %b",
               obs_vec(), exp_vec());
    end
  endtask

  task automatic test_start();
    tick(1, 0, 0);
    vectors++;
    if (gif.estado !== 3'b111 || gif.vidas !== 2'd3 ||
        gif.puntos !== 3'd0 || gif.rana_ini !== 1'b1 ||
        gif.bloqueo !== 1'b0) begin
      miscompares++;
      $display("FAIL start: got %b want 111_11_000_1_0",
               obs_vec());
    end
    tick(0, 0, 0);
    vectors++;
    if (obs_vec() !== exp_vec() || gif.rana_ini !== 1'b0) begin
      miscompares++;
      $display("FAIL start_rana_1clk: got %b want %b",
               obs_vec(), exp_vec());
    end
  endtask

  task automatic test_deaths();
    for (int k = 1; k <= 3; k++) begin
      tick(0, 1, 0);
      vectors++;
      if (gif.estado !== 3'b001 || gif.vidas !== 2'(3 - k)) begin
        miscompares++;
        $display("FAIL death%0d_enter: got %b/%0d want 001/%0d",
                 k, gif.estado, gif.vidas, 3 - k);
      end
      for (int c = 0; c < HOLD; c++) begin
        tick(0, c[0], ~c[0]);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL death%0d_hold%0d: got %b want %b",
                   k, c, obs_vec(), exp_vec());
        end
      end
      vectors++;
      if (k < 3 && (gif.estado !== 3'b111 || gif.rana_ini !== 1)) begin
        miscompares++;
        $display("FAIL death%0d_respawn: got %b want 111/rana 1",
                 k, gif.estado);
      end else if (k == 3 && (gif.estado !== 3'b100 ||
                              gif.vidas !== 2'd0)) begin
        miscompares++;
        $display("FAIL death_over: got %b/%0d want 100/0",
                 gif.estado, gif.vidas);
      end
    end
  endtask

  task automatic to_play();
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    vectors++;
    if (obs_vec() !== exp_vec() || gif.estado !== 3'b111) begin
      miscompares++;
      $display("FAIL to_play: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_goals();
    to_play();
    for (int k = 1; k <= META; k++) begin
      tick(0, 0, 1);
      vectors++;
      if (gif.estado !== 3'b010 || gif.puntos !== 3'(k)) begin
        miscompares++;
        $display("FAIL goal%0d_enter: got %b/%0d want 010/%0d",
                 k, gif.estado, gif.puntos, k);
      end
      for (int c = 0; c < HOLD; c++) begin
        tick(0, ~c[0], c[0]);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL goal%0d_hold%0d: got %b want %b",
                   k, c, obs_vec(), exp_vec());
        end
      end
    end
    vectors++;
    if (gif.estado !== 3'b110 || gif.rana_ini !== 1'b0 ||
        gif.puntos !== 3'd5) begin
      miscompares++;
      $display("FAIL victory: got %b want 110_11_101_0_1", obs_vec());
    end
  endtask

  task automatic test_both();
    to_play();
    tick(0, 0, 1);
    repeat (HOLD) tick(0, 0, 0);
    tick(0, 1, 1);
    vectors++;
    if (gif.estado !== 3'b001 || gif.vidas !== 2'd2 ||
        gif.puntos !== 3'd1) begin
      miscompares++;
      $display("FAIL both: got %b want 001_10_001_0_1", obs_vec());
    end
    repeat (HOLD) tick(0, 0, 0);
  endtask

  task automatic test_reset_mid_hold();
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst = 1'b1;
    gif.start = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs_vec() !== 10'b000_11_000_0_1) begin
      miscompares++;
      $display("FAIL reset_mid_hold: got %b want 000_11_000_0_1",
               obs_vec());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(1, 0, 0);
      vectors++;
      if (gif.estado !== 3'b000 || obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL held_start_after_reset%0d: got %b want %b",
                 c, obs_vec(), exp_vec());
      end
    end
    tick(0, 0, 0);
    tick(1, 0, 0);
    vectors++;
    if (gif.estado !== 3'b111 || gif.rana_ini !== 1'b1) begin
      miscompares++;
      $display("FAIL repress_after_reset: got %b want 111/rana 1",
               gif.estado);
    end
  endtask

  task automatic test_start_held_over();
    tick(0, 0, 0);
    repeat (3) begin
      tick(0, 1, 0);
      repeat (HOLD) tick(0, 0, 0);
    end
    for (int c = 0; c < 6; c++) begin
      tick(1, 0, 0);
      vectors++;
      if (gif.estado !== 3'b000 || obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL held_start_over%0d: got %b want 000",
                 c, gif.estado);
      end
    end
    tick(0, 0, 0);
    tick(1, 0, 0);
    vectors++;
    if (gif.estado !== 3'b111 || gif.vidas !== 2'd3) begin
      miscompares++;
      $display("FAIL second_edge_play: got %b want 111", gif.estado);
    end
  endtask

  task automatic test_random();
    bit s, p, g;
    for (int c = 0; c < 1500; c++) begin
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 9) == 0);
      g = ($urandom_range(0, 5) == 0);
      tick(s, p, g);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random%0d: got %b want %b",
                 c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_deaths();
    test_goals();
    test_both();
    test_reset_mid_hold();
    test_start_held_over();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
